// File: rtl/fir_ctrl.sv
// Frame sequencer for a memory-mapped FIR core: clears the filter, loads a frame, runs compute, then streams results out.
// Optional compute watchdog: define FIR_CTRL_TIMEOUT_EN to enable it (err then flags a stuck compute).
module fir_ctrl #(
  parameter int unsigned SIGNAL_LENGTH  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        out_last,
  output logic        fir_clr,
  output logic [1:0]  fir_op,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x,
  input  logic [31:0] fir_y,
  input  logic        fir_done,
  output logic        busy,
  output logic        err,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_LOAD     = 3'd2,
    S_COMPUTE  = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_CAP   = 3'd5,
    S_OUT      = 3'd6
  } state_t;

  localparam logic [1:0]  OP_IDLE  = 2'b00;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_COMP  = 2'b10;
  localparam logic [1:0]  OP_READ  = 2'b11;
  localparam logic [31:0] LAST_K   = 32'(SIGNAL_LENGTH - 1);

  if (SIGNAL_LENGTH == 0) begin : g_bad_len
    $error("fir_ctrl: SIGNAL_LENGTH must be at least 1");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_tmo
    $error("fir_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] k_q, k_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;

`ifdef FIR_CTRL_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // Both streams use valid/ready: a beat transfers on a rising edge where valid
  // and ready are both high; a source holds valid and data stable until then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef FIR_CTRL_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    in_ready    = 1'b0;
    fir_op      = OP_IDLE;
    fir_addr    = '0;
    fir_x       = '0;
`ifdef FIR_CTRL_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // The waiting sample is left on the bus; LOAD consumes it after the clear.
        if (in_valid) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        k_d     = '0;
        state_d = S_LOAD;
`ifdef FIR_CTRL_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fir_op   = OP_WRITE;
          fir_addr = k_q;
          fir_x    = in_data;
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            k_d = k_q + 32'd1;
          end
        end
      end

      S_COMPUTE: begin
        if (fir_done) begin
          state_d = S_RD_ISSUE;
        end else begin
          fir_op = OP_COMP;
`ifdef FIR_CTRL_TIMEOUT_EN
          tmo_d = tmo_q + 32'd1;
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = S_IDLE;
          end
`endif
        end
      end

      S_RD_ISSUE: begin
        fir_op   = OP_READ;
        fir_addr = k_q;
        state_d  = S_RD_CAP;
      end

      S_RD_CAP: begin
        // The filter registers its read data, so fir_y is valid one cycle after the issue.
        out_data_d  = fir_y;
        out_valid_d = 1'b1;
        out_last_d  = (k_q == LAST_K);
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            k_d        = '0;
            state_d    = S_IDLE;
          end else begin
            k_d     = k_q + 32'd1;
            state_d = S_RD_ISSUE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Nothing reaches the filter bus or the upstream handshake while reset is held.
    if (!reset) begin
      in_ready = 1'b0;
      fir_op   = OP_IDLE;
      fir_addr = '0;
      fir_x    = '0;
    end
  end

  assign fir_clr     = !reset || (state_q == S_CLEAR);
  assign busy        = reset && (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign dbg_state_o = state_q;

`ifdef FIR_CTRL_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: behavioural FIR core, valid/ready stimulus, and a scoreboard of expected filtered frames.
module tb_fir_ctrl;
  localparam int N   = 4;
  localparam int TMO = 50;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_last;
  logic        fir_clr;
  logic [1:0]  fir_op;
  logic [31:0] fir_addr;
  logic [31:0] fir_x;
  logic [31:0] fir_y;
  logic        fir_done;
  logic        busy;
  logic        err;
  logic [2:0]  dbg_state;

  fir_ctrl #(.SIGNAL_LENGTH(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
    .fir_clr(fir_clr), .fir_op(fir_op), .fir_addr(fir_addr), .fir_x(fir_x),
    .fir_y(fir_y), .fir_done(fir_done), .busy(busy), .err(err),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural FIR core: y[n] = sum coef[j]*x[n-j], done a few cycles into compute
  logic [31:0] coef[N];
  logic [31:0] xm[N];
  logic [31:0] ym[N];
  logic        done_q = 1'b0;
  int          cyc_q = 0;
  bit          stall_done = 1'b0;
  logic [31:0] model_acc;

  initial fir_y = '0;
  assign fir_done = done_q;

  always @(posedge clk) begin
    if (fir_clr) begin
      done_q <= 1'b0;
      cyc_q  <= 0;
      for (int i = 0; i < N; i++) xm[i] <= '0;
    end else begin
      case (fir_op)
        2'b01: if (fir_addr < N) xm[fir_addr] <= fir_x;
        2'b10: if (!stall_done && !done_q) begin
          cyc_q <= cyc_q + 1;
          if (cyc_q == 2) begin
            done_q <= 1'b1;
            for (int n = 0; n < N; n++) begin
              model_acc = '0;
              for (int j = 0; j <= n; j++) model_acc = model_acc + coef[j] * xm[n-j];
              ym[n] <= model_acc;
            end
          end
        end
        2'b11: if (fir_addr < N) fir_y <= ym[fir_addr];
        default: ;
      endcase
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_last_q[$];
  logic [31:0] frame_buf[N];

  task automatic push_exp();
    logic [31:0] acc;
    for (int n = 0; n < N; n++) begin
      acc = '0;
      for (int j = 0; j <= n; j++) acc = acc + coef[j] * frame_buf[n-j];
      exp_q.push_back(acc);
      exp_last_q.push_back((n == N - 1) ? 32'd1 : 32'd0);
    end
  endtask

  // monitor
  int          wr_idx = 0;
  int          rd_cnt = 0;
  int          cmp_cnt = 0;
  int          clr_cnt = 0;
  int          out_cnt = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  bit          chk_busy_fall = 1'b0;
  logic [31:0] e_data, e_last;

  always @(negedge clk) begin
    if (!reset) begin
      wr_idx    = 0;
      rd_cnt    = 0;
      cmp_cnt   = 0;
      prev_hold = 1'b0;
      chk_busy_fall = 1'b0;
    end else begin
      if (chk_busy_fall) begin
        check("busy_fall", {31'd0, busy}, 32'd0);
        chk_busy_fall = 1'b0;
      end
      if (fir_clr) begin
        wr_idx  = 0;
        rd_cnt  = 0;
        cmp_cnt = 0;
        clr_cnt++;
      end
      if (fir_op == 2'b01) begin
        check("wr_addr", fir_addr, wr_idx);
        check("wr_data", fir_x, in_data);
        wr_idx++;
      end
      if (fir_op == 2'b11) rd_cnt++;
      if (fir_op == 2'b10) cmp_cnt++;
      if (fir_op == 2'b00 || fir_op == 2'b10) check("bus_zero", fir_addr | fir_x, 32'd0);
      if (fir_op == 2'b10 || fir_op == 2'b11) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (out_valid) begin
        check("in_ready_ov", {31'd0, in_ready}, 32'd0);
        check("op_ov", {30'd0, fir_op}, 32'd0);
      end
      if (prev_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, hold_data);
        check("hold_last", {31'd0, out_last}, {31'd0, hold_last});
      end
      prev_hold = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_data, 32'hxxxx_xxxx);
        end else begin
          e_data = exp_q.pop_front();
          e_last = exp_last_q.pop_front();
          check("out_data", out_data, e_data);
          check("out_last", {31'd0, out_last}, e_last);
        end
        if (out_last) chk_busy_fall = 1'b1;
        out_cnt++;
      end
    end
  end

  // downstream driver: 0 always ready, 1 random, 2 stall at a chosen sample
  int rdy_mode   = 0;
  int stall_at   = -1;
  int stall_left = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (out_valid && out_cnt == stall_at && stall_left > 0) begin
             out_ready = 1'b0;
             stall_left--;
           end else begin
             out_ready = 1'b1;
           end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // upstream driver tasks
  task automatic drive_frame(input int gap, input bit push, input int nsamp, input bit hold);
    bit got;
    if (push) push_exp();
    for (int i = 0; i < nsamp; i++) begin
      if (gap == 1 && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (gap == 2) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = frame_buf[i];
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        got = in_ready;
        @(posedge clk); #1;
      end
      if (!got) check("in_hs_timeout", 32'd0, 32'd1);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = !busy && (exp_q.size() == 0);
    end
    if (!ok) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic end_frame_checks(input string tag);
    check({tag, "_writes"}, wr_idx, N);
    check({tag, "_reads"}, rd_cnt, N);
`ifndef FIR_CTRL_TIMEOUT_EN
    check({tag, "_err"}, {31'd0, err}, 32'd0);
`endif
  endtask

  task automatic set_coef(input logic [31:0] c0, input logic [31:0] c1);
    for (int i = 0; i < N; i++) coef[i] = '0;
    coef[0] = c0;
    coef[1] = c1;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) frame_buf[i] = $urandom;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_fir_op"}, {30'd0, fir_op}, 32'd0);
    check({tag, "_fir_bus"}, fir_addr | fir_x, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_fir_clr"}, {31'd0, fir_clr}, 32'd0);
  endtask

  int clr_base;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    set_coef(32'd1, 32'd0);

    // reset with a sample presented: must not be taken, filter held in clear
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fir_clr", {31'd0, fir_clr}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_fir_op", {30'd0, fir_op}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
    check("post_rst_err", {31'd0, err}, 32'd0);

    // frame with identity coefficients: 5,6,7,8 out unchanged
    frame_buf[0] = 32'd5; frame_buf[1] = 32'd6; frame_buf[2] = 32'd7; frame_buf[3] = 32'd8;
    clr_base = clr_cnt;
    @(posedge clk); #1;
    drive_frame(0, 1'b1, N, 1'b0);
    wait_idle("f1");
    end_frame_checks("f1");
    check("f1_clr", clr_cnt - clr_base, 1);

    // toggled in_valid, two-tap filter
    set_coef(32'd3, 32'd1);
    rand_frame();
    drive_frame(1, 1'b1, N, 1'b0);
    wait_idle("toggle");
    end_frame_checks("toggle");

    // 10-cycle downstream stall on the second output sample
    rand_frame();
    rdy_mode   = 2;
    stall_at   = out_cnt + 1;
    stall_left = 10;
    drive_frame(0, 1'b1, N, 1'b0);
    wait_idle("stall");
    end_frame_checks("stall");
    check("stall_used", stall_left, 0);
    rdy_mode = 0;

    // reset in the middle of LOAD at k=2
    rand_frame();
    drive_frame(0, 1'b0, 2, 1'b1);
    check("abort_writes", wr_idx, 2);
    in_data = 32'hdead_beef;
    reset   = 1'b0;
    @(negedge clk);
    check("abort_fir_clr", {31'd0, fir_clr}, 32'd1);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_fir_op", {30'd0, fir_op}, 32'd0);
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1;
    rand_frame();
    drive_frame(0, 1'b1, N, 1'b0);
    wait_idle("after_abort");
    end_frame_checks("after_abort");

    // back-to-back frames with in_valid held high, random downstream backpressure
    rdy_mode = 1;
    clr_base = clr_cnt;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      drive_frame(0, 1'b1, N, 1'b1);
    end
    in_valid = 1'b0;
    wait_idle("b2b");
    end_frame_checks("b2b");
    check("b2b_clr", clr_cnt - clr_base, 3);

    // random frames: random gaps, random coefficients, random backpressure
    for (int f = 0; f < 4; f++) begin
      set_coef($urandom_range(0, 9), $urandom_range(0, 9));
      rand_frame();
      drive_frame(2, 1'b1, N, 1'b0);
      wait_idle("rand");
      end_frame_checks("rand");
    end
    rdy_mode = 0;

`ifdef FIR_CTRL_TIMEOUT_EN
    // stuck compute: watchdog fires after TMO compute cycles, then frames still work
    stall_done = 1'b1;
    rand_frame();
    drive_frame(0, 1'b0, N, 1'b0);
    wait_idle("tmo");
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_cycles", cmp_cnt, TMO);
    check("tmo_state", {29'd0, dbg_state}, 32'd0);
    stall_done = 1'b0;
    set_coef(32'd1, 32'd0);
    rand_frame();
    drive_frame(0, 1'b1, N, 1'b0);
    wait_idle("post_tmo");
    end_frame_checks("post_tmo");
    check("post_tmo_err", {31'd0, err}, 32'd1);
`else
    check("no_tmo_err", {31'd0, err}, 32'd0);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
